// File: rtl/onehot_arb_pkg.sv
// ----------------------------------------------------------------------------
// onehot_arb_pkg
//   Shared types and helpers for the one-hot round-robin arbiter.
//   - state_t : one-hot FSM encoding (IDLE/OWN/GAP)
//   - rotl1   : rotate a vector of 'width' bits left by one (MSB wraps to bit 0)
//   - oh2bin  : binary index of a one-hot vector (0 for an all-zero vector)
//   Vectors are passed zero-extended to VEC_W bits so the helpers work for
//   any requester count up to VEC_W.
// ----------------------------------------------------------------------------
package onehot_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    OWN  = 3'b010,
    GAP  = 3'b100
  } state_t;

  localparam int VEC_W = 32;
  localparam int BIN_W = 5;

  function automatic logic [VEC_W-1:0] rotl1(input logic [VEC_W-1:0] v,
                                             input int width);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 1; i < VEC_W; i++) begin
      if (i < width) r[i] = v[i-1];
    end
    if (width >= 1 && width <= VEC_W) r[0] = v[width-1];
    return r;
  endfunction

  function automatic logic [BIN_W-1:0] oh2bin(input logic [VEC_W-1:0] v);
    logic [BIN_W-1:0] b;
    b = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (v[i]) b = b | BIN_W'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/onehot_rr_pick.sv
// ----------------------------------------------------------------------------
// onehot_rr_pick
//   Combinational round-robin selector: returns the first set request at or
//   after the one-hot pointer, wrapping from N-1 back to 0.
// Ports
//   req  [N-1:0] in   request vector
//   ptr  [N-1:0] in   one-hot priority pointer (bit set = highest priority)
//   pick [N-1:0] out  one-hot selected request, zero when req==0
// ----------------------------------------------------------------------------
module onehot_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] base;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // The lower copy of req loses every bit below ptr; the upper copy keeps
  // all of them, which provides the wrap-around. The lowest surviving bit
  // is the winner, folded back onto N bits.
  assign dbl    = {req, req};
  assign base   = {{N{1'b0}}, ptr};
  assign masked = dbl & ~(base - (2*N)'(1));
  assign first  = masked & (~masked + (2*N)'(1));
  assign pick   = first[N-1:0] | first[2*N-1:N];

endmodule

// File: rtl/onehot_rr_arbiter.sv
// ----------------------------------------------------------------------------
// onehot_rr_arbiter
//   Round-robin arbiter sharing one resource among N requesters. A grant is
//   held until the owner releases it, its request drops, or MAX_HOLD cycles
//   elapse (MAX_HOLD=0 disables the timeout). Every owner change passes
//   through a one-cycle GAP with no grant. All outputs are registered.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | no owner; sample req and pick the next owner
//   OWN   | grant held; count hold cycles, watch for exit
//   GAP   | one dead cycle for resource turnaround
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   req  [N]   in   level request per requester
//   rel        in   owner finished; only honoured in OWN
//   gnt  [N]   out  one-hot grant, zero when no owner
//   gnt_vld    out  |gnt
//   gnt_id     out  binary index of the owner, 0 when gnt_vld=0
//   busy       out  FSM not in IDLE
//   timeout    out  one-cycle pulse when a grant is revoked by MAX_HOLD
//   onehot_err out  sticky grant/state integrity error
//
// Build option: define ONEHOT_ARB_CHECK_EN to compile the integrity checks;
// otherwise onehot_err is tied low.
// ----------------------------------------------------------------------------
module onehot_rr_arbiter
  import onehot_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            rel,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout,
  output logic            onehot_err
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  state_t            state_q, state_nxt;
  logic [N-1:0]      gnt_q, gnt_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic [HW-1:0]     hold_q, hold_nxt;
  logic [N-1:0]      ptr_q, ptr_nxt;
  logic              vld_q, busy_q, to_q, to_nxt;
  logic [N-1:0]      pick;
  logic              hold_lim;
  logic              owner_gone;

  onehot_rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  assign hold_lim   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign owner_gone = ~|(req & gnt_q);

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    hold_nxt  = hold_q;
    ptr_nxt   = ptr_q;
    to_nxt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          gnt_nxt   = pick;
          id_nxt    = ID_W'(oh2bin(VEC_W'(pick)));
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (rel || owner_gone || hold_lim) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          id_nxt    = '0;
          hold_nxt  = '0;
          ptr_nxt   = N'(rotl1(VEC_W'(gnt_q), N));
          // A release in the last allowed cycle is a normal hand-back.
          to_nxt    = hold_lim && !rel;
        end else begin
          hold_nxt = hold_q + HW'(1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      ptr_q   <= N'(1);
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      id_q    <= id_nxt;
      hold_q  <= hold_nxt;
      ptr_q   <= ptr_nxt;
      vld_q   <= |gnt_nxt;
      busy_q  <= (state_nxt != IDLE);
      to_q    <= to_nxt;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_id  = id_q;
  assign busy    = busy_q;
  assign timeout = to_q;

`ifdef ONEHOT_ARB_CHECK_EN
  logic err_q;
  logic integ_ok;

  // Checks look at the gnt port itself so that any disturbance of the
  // driven grant is caught, not only the internal register.
  assign integ_ok = $onehot0(gnt) && $onehot(state_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (!integ_ok) begin
      err_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      a_integ: assert (integ_ok)
        else $error("%0t onehot_rr_arbiter integrity: gnt=%b state=%b",
                    $time, gnt, state_q);
    end
  end

  assign onehot_err = err_q;
`else
  assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
module tb_onehot_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic       onehot_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         is_to;
    logic [3:0] g;
    logic [1:0] id;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en   = 1'b1;
  bit   prev_vld = 1'b0;

  onehot_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rel        (rel),
    .gnt        (gnt),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .timeout    (timeout),
    .onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input logic [3:0] g, input logic [1:0] id);
    exp_t e;
    e.is_to = 1'b0; e.g = g; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic push_to();
    exp_t e;
    e.is_to = 1'b1; e.g = 4'b0000; e.id = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy !== 1'b0; k++) tick();
    chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: a new grant (gnt_vld rising) or a timeout pulse pops the next
  // expected event; every cycle the grant is also checked for integrity.
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt_vld === 1'b1 && !prev_vld) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_grant: got gnt=%b", gnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_kind_grant", {31'd0, e.is_to}, 32'd0);
          chk("sb_gnt", {28'd0, gnt}, {28'd0, e.g});
          chk("sb_gnt_id", {30'd0, gnt_id}, {30'd0, e.id});
        end
      end
      if (timeout === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_timeout: got timeout=1 gnt=%b", gnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_kind_timeout", {31'd0, e.is_to}, 32'd1);
          chk("sb_timeout_gnt", {28'd0, gnt}, 32'd0);
        end
      end
      if (rst === 1'b1 && gnt_vld === 1'b1) begin
        chk("onehot_gnt", {31'd0, $onehot(gnt)}, 32'd1);
      end
      prev_vld = (gnt_vld === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_g [4];
    logic [1:0] rr_id[4];
    rr_g[0] = 4'b0010; rr_id[0] = 2'd1;
    rr_g[1] = 4'b0100; rr_id[1] = 2'd2;
    rr_g[2] = 4'b1000; rr_id[2] = 2'd3;
    rr_g[3] = 4'b0001; rr_id[3] = 2'd0;

    // 1 reset with all requests pending
    rst = 1'b0; req = 4'b1111; rel = 1'b0;
    tick(); tick();
    chk("rst_gnt",     {28'd0, gnt}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_gnt_id",  {30'd0, gnt_id}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_vld",     {31'd0, gnt_vld}, 32'd0);
    chk("rst_err",     {31'd0, onehot_err}, 32'd0);
    push_gnt(4'b0001, 2'd0);
    rst = 1'b1;
    tick();
    chk("first_gnt", {28'd0, gnt}, 32'b0001);

    // 3 round robin with all requests held
    for (int i = 0; i < 4; i++) begin
      push_gnt(rr_g[i], rr_id[i]);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk("rr_gap_gnt", {28'd0, gnt}, 32'd0);
      tick();
      tick();
      chk("rr_next_gnt", {28'd0, gnt}, {28'd0, rr_g[i]});
    end
    req = 4'b0000;
    wait_idle();

    // 2 single requester with release latency
    req = 4'b0100;
    push_gnt(4'b0100, 2'd2);
    tick();
    chk("single_gnt",    {28'd0, gnt}, 32'b0100);
    chk("single_gnt_id", {30'd0, gnt_id}, 32'd2);
    tick();
    tick();
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 4'b0000;
    chk("single_rel_gnt",  {28'd0, gnt}, 32'd0);
    chk("single_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("single_idle_busy", {31'd0, busy}, 32'd0);
    wait_idle();

    // 4 timeout after MAX_HOLD cycles, then re-grant of the sole requester
    req = 4'b0001;
    push_gnt(4'b0001, 2'd0);
    push_to();
    push_gnt(4'b0001, 2'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_hold_gnt", {28'd0, gnt}, 32'b0001);
      tick();
    end
    chk("to_pulse",    {31'd0, timeout}, 32'd1);
    chk("to_gap_gnt",  {28'd0, gnt}, 32'd0);
    tick();
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    chk("to_idle_gnt",  {28'd0, gnt}, 32'd0);
    tick();
    chk("to_regrant", {28'd0, gnt}, 32'b0001);
    req = 4'b0000;
    wait_idle();

    // 5 reset while requester 2 owns the grant
    req = 4'b0100;
    push_gnt(4'b0100, 2'd2);
    tick();
    chk("mid_owner", {28'd0, gnt}, 32'b0100);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_gnt",  {28'd0, gnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_vld",  {31'd0, gnt_vld}, 32'd0);
    rst = 1'b1; req = 4'b0110;
    push_gnt(4'b0010, 2'd1);
    tick();
    chk("mid_regrant", {28'd0, gnt}, 32'b0010);

    // release in the last allowed hold cycle: no timeout pulse
    for (int i = 0; i < 7; i++) tick();
    push_gnt(4'b0100, 2'd2);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("coinc_timeout", {31'd0, timeout}, 32'd0);
    chk("coinc_gnt",     {28'd0, gnt}, 32'd0);
    tick();
    tick();
    chk("coinc_next_gnt", {28'd0, gnt}, 32'b0100);
    req = 4'b0000;
    wait_idle();

    // 6 integrity check on a corrupted grant
    mon_en = 1'b0;
    force dut.gnt = 4'b0110;
    tick();
    release dut.gnt;
    tick();
`ifdef ONEHOT_ARB_CHECK_EN
    chk("integ_err_set", {31'd0, onehot_err}, 32'd1);
    tick();
    chk("integ_err_sticky", {31'd0, onehot_err}, 32'd1);
`else
    chk("integ_err_off", {31'd0, onehot_err}, 32'd0);
    tick();
    chk("integ_err_off_hold", {31'd0, onehot_err}, 32'd0);
`endif
    prev_vld = 1'b0;
    mon_en = 1'b1;
    tick();

    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
